// File: rtl/fp_result_composer_if.sv
// Raw-result input and packed-result output of the FP add/sub back end.
// Carries both valid/ready handshakes; no logic inside.
// master = producer/consumer side, slave = the composer itself.
interface fp_result_composer_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sign;
    logic [EXP_W-1:0]          in_exponent;
    logic [FRAC_W+3:0]         in_mantissa;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W+FRAC_W:0]     out_result;

    modport master (
        output in_valid, in_sign, in_exponent, in_mantissa, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_sign, in_exponent, in_mantissa, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface

// File: rtl/fp_result_composer.sv
// Normalizes, rounds (RNE) and packs the adder's raw sign/exponent/mantissa into IEEE-754.
// Latency: 3+k cycles from accept to out_valid (k = left shifts), 2 for all-ones exponent pass-through.
// Backpressure: single op in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_result_composer #(
    parameter int EXP_W        = 8,
    parameter int FRAC_W       = 23,
    parameter int FLUSH_DENORM = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    fp_result_composer_if.slave  io
);
    localparam int MW = FRAC_W + 4;          // {carry, hidden, frac, guard, sticky}
    localparam int EW = EXP_W + 1;           // one spare bit so overflow is visible
    localparam int RW = 1 + EXP_W + FRAC_W;

    localparam logic [EW-1:0] EXP_ONE = EW'(1);
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state;
    logic            sign_q;
    logic [EW-1:0]   exp_q;
    logic [MW-1:0]   man_q;
    logic            special_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [RW-1:0]   result_q;

    // Rounding datapath, evaluated on the normalized mantissa held during ROUND.
    logic [FRAC_W-1:0] frac;
    logic              hidden;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [FRAC_W+1:0] sig_sum;
    logic [EW-1:0]     r_exp;
    logic [FRAC_W-1:0] r_frac;
    logic [RW-1:0]     round_result;

    // Round to nearest-even, then fold in fraction carry-out, subnormal promotion, overflow and flush.
    always_comb begin
        hidden  = man_q[FRAC_W+2];
        frac    = man_q[FRAC_W+1:2];
        guard   = man_q[1];
        sticky  = man_q[0];
        inc     = guard & (sticky | frac[0]);
        sig_sum = {1'b0, hidden, frac} + {{(FRAC_W+1){1'b0}}, inc};
        r_exp   = exp_q;
        r_frac  = sig_sum[FRAC_W-1:0];
        if (sig_sum[FRAC_W+1]) begin
            // 1.111..1 rounded up to 10.000..0
            r_frac = '0;
            r_exp  = exp_q + EXP_ONE;
        end else if (exp_q == '0 && sig_sum[FRAC_W]) begin
            // largest subnormal rounded up into the smallest normal
            r_exp = EXP_ONE;
        end
        if (r_exp >= EXP_MAX) begin
            r_exp  = EXP_MAX;
            r_frac = '0;
        end else if (FLUSH_DENORM != 0 && r_exp == '0) begin
            r_frac = '0;
        end
        round_result = {sign_q, r_exp[EXP_W-1:0], r_frac};
    end

    // Control FSM plus normalization shifter; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            man_q       <= '0;
            special_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        sign_q     <= io.in_sign;
                        exp_q      <= {1'b0, io.in_exponent};
                        man_q      <= io.in_mantissa;
                        special_q  <= (io.in_exponent == {EXP_W{1'b1}});
                        in_ready_q <= 1'b0;
                        state      <= NORM;
                    end
                end
                NORM: begin
                    if (special_q) begin
                        // Inf/NaN inputs bypass rounding entirely
                        result_q    <= {sign_q, {EXP_W{1'b1}}, man_q[FRAC_W+1:2]};
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (man_q == '0) begin
                        exp_q <= '0;
                        state <= ROUND;
                    end else if (man_q[MW-1]) begin
                        // carry out of the adder: shift right, keep sticky information
                        man_q <= {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
                        exp_q <= exp_q + EXP_ONE;
                        state <= ROUND;
                    end else if (man_q[MW-2]) begin
                        state <= ROUND;
                    end else if (exp_q > EXP_ONE) begin
                        // cancellation: one left shift per cycle
                        man_q <= {man_q[MW-2:0], 1'b0};
                        exp_q <= exp_q - EXP_ONE;
                    end else begin
                        // ran out of exponent range: result is subnormal
                        exp_q <= '0;
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= round_result;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.in_ready   = in_ready_q;
    assign io.out_valid  = out_valid_q;
    assign io.out_result = result_q;

endmodule

// File: tb/tb_fp_result_composer.sv
// Directed bench for fp_result_composer: two instances (flush off / flush on) share one stimulus stream.
// Expected words are queued at send time and popped when out_valid is seen.
// Cycle numbering: cycle 1 is the cycle right after the accept edge.
module tb_fp_result_composer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [26:0] in_mantissa;
    logic        out_ready;

    fp_result_composer_if #(.EXP_W(8), .FRAC_W(23)) if0 ();
    fp_result_composer_if #(.EXP_W(8), .FRAC_W(23)) if1 ();

    assign if0.in_valid    = in_valid;
    assign if0.in_sign     = in_sign;
    assign if0.in_exponent = in_exponent;
    assign if0.in_mantissa = in_mantissa;
    assign if0.out_ready   = out_ready;
    assign if1.in_valid    = in_valid;
    assign if1.in_sign     = in_sign;
    assign if1.in_exponent = in_exponent;
    assign if1.in_mantissa = in_mantissa;
    assign if1.out_ready   = out_ready;

    fp_result_composer #(.EXP_W(8), .FRAC_W(23), .FLUSH_DENORM(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .io  (if0.slave)
    );

    fp_result_composer #(.EXP_W(8), .FRAC_W(23), .FLUSH_DENORM(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .io  (if1.slave)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [26:0] mk(input logic c, input logic h, input logic [22:0] f,
                                       input logic g, input logic s);
        return {c, h, f, g, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one raw result and hold it until the accept edge.
    task automatic send(input string tag, input logic s, input logic [7:0] e, input logic [26:0] m,
                        input logic [31:0] e0, input logic [31:0] e1, input bit push);
        int n = 0;
        while (!if0.in_ready && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, {31'd0, if0.in_ready}, 32'd1);
        in_sign     = s;
        in_exponent = e;
        in_mantissa = m;
        in_valid    = 1'b1;
        if (push) begin
            sb0.push_back(e0);
            sb1.push_back(e1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for the result, score it, optionally stall the consumer, then complete the handshake.
    task automatic collect(input string tag, input int exp_lat, input int hold);
        int cycle = 1;
        logic [31:0] want0;
        logic [31:0] want1;
        out_ready = (hold == 0);
        while (!if0.out_valid && cycle < 100) begin
            tick();
            cycle++;
        end
        check({tag, "_latency"}, cycle, exp_lat);
        check({tag, "_valid_flush"}, {31'd0, if1.out_valid}, 32'd1);
        want0 = sb0.pop_front();
        want1 = sb1.pop_front();
        check({tag, "_result"}, if0.out_result, want0);
        check({tag, "_result_flush"}, if1.out_result, want1);
        if (hold > 0) begin
            // a second request during the stall must be ignored
            in_sign     = 1'b1;
            in_exponent = 8'hFF;
            in_mantissa = mk(1'b0, 1'b1, 23'h123456, 1'b0, 1'b0);
            in_valid    = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                check({tag, "_hold_result"}, if0.out_result, want0);
                check({tag, "_hold_valid"}, {31'd0, if0.out_valid}, 32'd1);
                check({tag, "_hold_in_ready"}, {31'd0, if0.in_ready}, 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check({tag, "_post_valid"}, {31'd0, if0.out_valid}, 32'd0);
        check({tag, "_post_in_ready"}, {31'd0, if0.in_ready}, 32'd1);
        check({tag, "_post_result_kept"}, if0.out_result, want0);
    endtask

    initial begin
        int vcount;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sign     = 1'b0;
        in_exponent = 8'd0;
        in_mantissa = 27'd0;
        out_ready   = 1'b1;
        repeat (3) tick();
        check("reset_in_ready", {31'd0, if0.in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, if0.out_valid}, 32'd0);
        check("reset_out_result", if0.out_result, 32'd0);
        check("reset_out_valid_flush", {31'd0, if1.out_valid}, 32'd0);
        rst = 1'b0;
        tick();

        send("one_plus_one", 1'b0, 8'd127, mk(1'b1, 1'b0, 23'h0, 1'b0, 1'b0), 32'h40000000, 32'h40000000, 1'b1);
        collect("one_plus_one", 3, 0);

        send("cancel_k5", 1'b0, 8'd127, mk(1'b0, 1'b0, 23'h040000, 1'b0, 1'b0), 32'h3D000000, 32'h3D000000, 1'b1);
        collect("cancel_k5", 8, 0);

        send("rne_tie_odd", 1'b0, 8'd127, mk(1'b0, 1'b1, 23'h1, 1'b1, 1'b0), 32'h3F800002, 32'h3F800002, 1'b1);
        collect("rne_tie_odd", 3, 0);

        send("rne_tie_even", 1'b0, 8'd127, mk(1'b0, 1'b1, 23'h0, 1'b1, 1'b0), 32'h3F800000, 32'h3F800000, 1'b1);
        collect("rne_tie_even", 3, 0);

        send("rne_above_half", 1'b0, 8'd127, mk(1'b0, 1'b1, 23'h0, 1'b1, 1'b1), 32'h3F800001, 32'h3F800001, 1'b1);
        collect("rne_above_half", 3, 0);

        send("overflow_pos", 1'b0, 8'd254, mk(1'b0, 1'b1, 23'h7FFFFF, 1'b1, 1'b0), 32'h7F800000, 32'h7F800000, 1'b1);
        collect("overflow_pos", 3, 0);

        send("overflow_neg", 1'b1, 8'd254, mk(1'b0, 1'b1, 23'h7FFFFF, 1'b1, 1'b0), 32'hFF800000, 32'hFF800000, 1'b1);
        collect("overflow_neg", 3, 0);

        send("underflow", 1'b0, 8'd1, mk(1'b0, 1'b0, 23'h400000, 1'b0, 1'b0), 32'h00400000, 32'h00000000, 1'b1);
        collect("underflow", 3, 0);

        send("special_nan", 1'b0, 8'd255, mk(1'b0, 1'b1, 23'h400000, 1'b0, 1'b0), 32'h7FC00000, 32'h7FC00000, 1'b1);
        collect("special_nan", 2, 0);

        send("zero_neg", 1'b1, 8'd127, 27'd0, 32'h80000000, 32'h80000000, 1'b1);
        collect("zero_neg", 3, 0);

        send("hold", 1'b0, 8'd127, mk(1'b0, 1'b1, 23'h1, 1'b1, 1'b0), 32'h3F800002, 32'h3F800002, 1'b1);
        collect("hold", 3, 5);
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if0.out_valid) vcount++;
        end
        check("hold_second_request_ignored", vcount, 0);

        // abort mid-normalization
        send("reset_in_norm", 1'b0, 8'd127, mk(1'b0, 1'b0, 23'h040000, 1'b0, 1'b0), 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_in_norm_in_ready", {31'd0, if0.in_ready}, 32'd1);
        check("reset_in_norm_out_valid", {31'd0, if0.out_valid}, 32'd0);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if0.out_valid || if1.out_valid) vcount++;
        end
        check("reset_in_norm_no_result", vcount, 0);

        send("after_reset", 1'b0, 8'd127, mk(1'b1, 1'b0, 23'h0, 1'b0, 1'b0), 32'h40000000, 32'h40000000, 1'b1);
        collect("after_reset", 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
